// File: rtl/e16_arbiter_multimode.sv
// ARW-way arbiter with runtime fixed-priority / round-robin selection, grant locking via
// 'hold', and an optional hold timeout that forcibly releases a lock.
module e16_arbiter_multimode #(
  parameter int ARW      = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clk_en,
  input  logic           mode,
  input  logic           hold,
  input  logic [ARW-1:0] request,
  output logic [ARW-1:0] grant,
  output logic [ARW-1:0] arb_wait,
  output logic           lock_active,
  output logic           hold_timeout,
  output logic           lock_drop_err
);

  localparam int PTRW = (ARW > 1) ? $clog2(ARW) : 1;
  localparam int CNTW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  logic [ARW-1:0]  lock_q, lock_d;
  logic [PTRW-1:0] ptr_q, ptr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;
  logic            drop_q, drop_d;

  logic            locked;
  logic            release_to;
  logic [ARW-1:0]  fp_grant;
  logic [ARW-1:0]  rr_grant;
  logic            rr_found;
  logic [PTRW-1:0] rr_idx;
  logic [PTRW-1:0] gnt_idx;
  logic [PTRW-1:0] idx_or [ARW+1];

  // A lock only counts while its owner is still requesting.
  assign locked = |(lock_q & request);

  genvar gi;
  generate
    for (gi = 0; gi < ARW; gi++) begin : g_fp
      if (gi == 0) begin : g_first
        assign fp_grant[gi] = request[gi];
      end else begin : g_rest
        assign fp_grant[gi] = request[gi] & ~(|request[gi-1:0]);
      end
    end
  endgenerate

  always_comb begin
    rr_grant = '0;
    rr_found = 1'b0;
    rr_idx   = ptr_q;
    for (int k = 0; k < ARW; k++) begin
      if (!rr_found && request[rr_idx]) begin
        rr_grant[rr_idx] = 1'b1;
        rr_found         = 1'b1;
      end
      rr_idx = (rr_idx == PTRW'(ARW - 1)) ? '0 : rr_idx + 1'b1;
    end
  end

  assign grant = locked ? lock_q : (mode ? rr_grant : fp_grant);

  // Grant is one-hot, so OR-ing the per-bit indices yields the encoded winner.
  assign idx_or[0] = '0;
  generate
    for (gi = 0; gi < ARW; gi++) begin : g_enc
      assign idx_or[gi+1] = idx_or[gi] | (grant[gi] ? PTRW'(gi) : '0);
    end
  endgenerate
  assign gnt_idx = idx_or[ARW];

  generate
    if (MAX_HOLD != 0) begin : g_timeout
      assign release_to = locked & hold & (cnt_q == CNTW'(MAX_HOLD - 1));
    end else begin : g_no_timeout
      assign release_to = 1'b0;
    end
  endgenerate

  always_comb begin
    lock_d    = release_to ? '0 : (grant & {ARW{hold}});
    cnt_d     = (locked & hold & ~release_to) ? cnt_q + 1'b1 : '0;
    timeout_d = release_to;
    drop_d    = (|lock_q) & ~locked;
    ptr_d     = ptr_q;
    // Advance past the winner only when its grant ends this cycle.
    if ((|grant) && !(|lock_d)) begin
      ptr_d = (gnt_idx == PTRW'(ARW - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_q    <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      drop_q    <= 1'b0;
    end else if (clk_en) begin
      lock_q    <= lock_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      drop_q    <= drop_d;
    end
  end

  assign arb_wait      = request & (~grant | {ARW{hold}});
  assign lock_active   = |lock_q;
  assign hold_timeout  = timeout_q;
  assign lock_drop_err = drop_q;

endmodule

// File: tb/tb_e16_arbiter_multimode.sv
// Bench for e16_arbiter_multimode: owner/run-length model checked every negedge, plus
// directed scenarios with hand-computed grants.
module tb_e16_arbiter_multimode;

  localparam int ARW  = 4;
  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       clk_en;
  logic       mode;
  logic       hold;
  logic [3:0] request;
  logic [3:0] grant;
  logic [3:0] arb_wait;
  logic       lock_active;
  logic       hold_timeout;
  logic       lock_drop_err;

  int n_tests = 0;
  int n_fail  = 0;
  bit run_chk = 1'b0;

  // Model: current lock owner (-1 none), grant cycles given in the current run,
  // round-robin start position, and the two registered pulses.
  int m_owner = -1;
  int m_run   = 0;
  int m_ptr   = 0;
  bit m_to    = 1'b0;
  bit m_drop  = 1'b0;

  e16_arbiter_multimode #(.ARW(ARW), .MAX_HOLD(MAXH)) dut (
    .clk          (clk),
    .reset        (reset),
    .clk_en       (clk_en),
    .mode         (mode),
    .hold         (hold),
    .request      (request),
    .grant        (grant),
    .arb_wait     (arb_wait),
    .lock_active  (lock_active),
    .hold_timeout (hold_timeout),
    .lock_drop_err(lock_drop_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit f_locked();
    bit r;
    r = 1'b0;
    if (m_owner >= 0) r = request[m_owner];
    return r;
  endfunction

  function automatic int f_winner();
    int  w;
    bit  found;
    int  j;
    w     = -1;
    found = 1'b0;
    if (f_locked()) begin
      w     = m_owner;
      found = 1'b1;
    end
    for (int k = 0; k < ARW; k++) begin
      j = mode ? (m_ptr + k) % ARW : k;
      if (!found && request[j]) begin
        w     = j;
        found = 1'b1;
      end
    end
    return w;
  endfunction

  function automatic int f_new_run();
    int r;
    r = 0;
    if (f_winner() >= 0 && hold) r = f_locked() ? m_run + 1 : 1;
    return r;
  endfunction

  function automatic bit f_timeout();
    return (MAXH != 0) && (f_new_run() > MAXH);
  endfunction

  function automatic int f_next_owner();
    return (f_new_run() == 0 || f_timeout()) ? -1 : f_winner();
  endfunction

  function automatic bit f_dropped();
    return (m_owner >= 0) && !f_locked();
  endfunction

  function automatic logic [3:0] f_grant();
    int w;
    w = f_winner();
    return (w < 0) ? 4'b0000 : 4'(1 << w);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_owner <= -1;
      m_run   <= 0;
      m_ptr   <= 0;
      m_to    <= 1'b0;
      m_drop  <= 1'b0;
    end else if (clk_en) begin
      m_owner <= f_next_owner();
      m_run   <= f_timeout() ? 0 : f_new_run();
      m_to    <= f_timeout();
      m_drop  <= f_dropped();
      if (f_winner() >= 0 && f_next_owner() < 0) m_ptr <= (f_winner() + 1) % ARW;
    end
  end

  always @(negedge clk) begin
    if (run_chk) begin
      chk("m_grant", grant, f_grant());
      chk("m_arb_wait", arb_wait, request & (~f_grant() | {4{hold}}));
      chk("m_lock_active", lock_active, m_owner >= 0);
      chk("m_hold_timeout", hold_timeout, m_to);
      chk("m_lock_drop_err", lock_drop_err, m_drop);
    end
  end

  task automatic drive(input bit ce, input bit md, input bit hd, input logic [3:0] rq);
    @(posedge clk);
    #1;
    clk_en  = ce;
    mode    = md;
    hold    = hd;
    request = rq;
    #2;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset   = 1'b1;
    request = 4'b0000;
    hold    = 1'b0;
    clk_en  = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  logic [3:0] exp_rr [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic       t3_hold [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [3:0] t3_gnt [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
  logic       t3_lock [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [3:0] t3_wait [5] = '{4'b0011, 4'b0011, 4'b0011, 4'b0010, 4'b0001};
  logic [3:0] t5_gnt [5] = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
  bit         t5_en [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    reset   = 1'b1;
    clk_en  = 1'b1;
    mode    = 1'b0;
    hold    = 1'b0;
    request = 4'b0000;
    #6 run_chk = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    #2;
    chk("rst_grant", grant, 4'b0000);
    chk("rst_lock", lock_active, 1'b0);
    chk("rst_timeout", hold_timeout, 1'b0);
    chk("rst_drop", lock_drop_err, 1'b0);

    // Fixed priority
    drive(1'b1, 1'b0, 1'b0, 4'b1010);
    chk("fp_grant", grant, 4'b0010);
    chk("fp_wait", arb_wait, 4'b1000);

    // Round-robin rotation
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b0, 4'b1111);
      chk("rr_grant", grant, exp_rr[i]);
    end

    // Multi-cycle hold
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, t3_hold[i], 4'b0011);
      chk("hold_grant", grant, t3_gnt[i]);
      chk("hold_lock", lock_active, t3_lock[i]);
      chk("hold_wait", arb_wait, t3_wait[i]);
    end

    // Hold timeout
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 4'b0100);
    chk("to_first", grant, 4'b0100);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b1, 4'b0101);
      chk("to_locked", grant, 4'b0100);
      chk("to_nopulse", hold_timeout, 1'b0);
    end
    drive(1'b1, 1'b1, 1'b1, 4'b0101);
    chk("to_regrant", grant, 4'b0001);
    chk("to_pulse", hold_timeout, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 4'b0101);
    chk("to_pulse_end", hold_timeout, 1'b0);
    chk("to_relock", lock_active, 1'b1);

    // Clock enable freeze, then asynchronous reset mid-lock
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(t5_en[i], 1'b1, 1'b0, 4'b1111);
      chk("cen_grant", grant, t5_gnt[i]);
    end
    drive(1'b1, 1'b1, 1'b1, 4'b1111);
    chk("lk_grant", grant, 4'b1000);
    drive(1'b1, 1'b1, 1'b1, 4'b1111);
    chk("lk_held", grant, 4'b1000);
    chk("lk_active", lock_active, 1'b1);
    reset = 1'b1;
    #1;
    chk("arst_lock", lock_active, 1'b0);
    chk("arst_grant", grant, 4'b0001);
    request = 4'b0000;
    hold    = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;

    // Locked requester drops its request
    drive(1'b1, 1'b1, 1'b1, 4'b1001);
    chk("drop_first", grant, 4'b0001);
    drive(1'b1, 1'b1, 1'b0, 4'b1000);
    chk("drop_regrant", grant, 4'b1000);
    chk("drop_nopulse", lock_drop_err, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 4'b1000);
    chk("drop_pulse", lock_drop_err, 1'b1);
    chk("drop_unlock", lock_active, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 4'b0000);
    chk("drop_pulse_end", lock_drop_err, 1'b0);
    chk("idle_grant", grant, 4'b0000);

    @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
